// File: rtl/db_cbf_ram_ctrl.sv
// Sequencer and arbiter for the deblocking CBF flag RAM (64x16, single port).
// Shares the port between a read-modify-write flag writer and a word reader, and runs a full clear.
module db_cbf_ram_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr_start_i,
   output logic        clr_busy_o,
   output logic        clr_done_o,
   input  logic        wr_req_i,
   input  logic [5:0]  wr_adr_i,
   input  logic [15:0] wr_msk_i,
   input  logic [15:0] wr_dat_i,
   output logic        wr_ack_o,
   input  logic        rd_req_i,
   input  logic [5:0]  rd_adr_i,
   output logic        rd_ack_o,
   output logic        rd_vld_o,
   output logic [15:0] rd_dat_o,
   output logic [5:0]  ram_adr_o,
   output logic        ram_cen_o,
   output logic        ram_wen_o,
   output logic [15:0] ram_wr_dat_o,
   input  logic [15:0] ram_rd_dat_i
);

   typedef enum logic [1:0] {IDLE, RMW_WR, CLR} state_t;

   state_t      state;
   logic [5:0]  cnt;
   logic [5:0]  adr_q;
   logic [15:0] msk_q;
   logic [15:0] dat_q;
   logic        rd_pri;
   logic        arb_ok;

   assign clr_busy_o = (state == CLR);
   assign rd_dat_o   = ram_rd_dat_i;

   // rd_pri holds the round-robin pointer: set when the reader lost the last contested cycle
   always_comb begin
      arb_ok       = (state == IDLE) && !clr_start_i;
      rd_ack_o     = arb_ok && rd_req_i && (!wr_req_i || rd_pri);
      wr_ack_o     = arb_ok && wr_req_i && (!rd_req_i || !rd_pri);
      ram_cen_o    = 1'b1;
      ram_wen_o    = 1'b1;
      ram_adr_o    = '0;
      ram_wr_dat_o = '0;
      case (state)
         IDLE: begin
            if (rd_ack_o) begin
               ram_cen_o = 1'b0;
               ram_adr_o = rd_adr_i;
            end else if (wr_ack_o) begin
               ram_cen_o = 1'b0;
               ram_adr_o = wr_adr_i;
            end
         end
         RMW_WR: begin
            ram_cen_o    = 1'b0;
            ram_wen_o    = 1'b0;
            ram_adr_o    = adr_q;
            ram_wr_dat_o = (ram_rd_dat_i & ~msk_q) | (dat_q & msk_q);
         end
         CLR: begin
            ram_cen_o = 1'b0;
            ram_wen_o = 1'b0;
            ram_adr_o = cnt;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         adr_q      <= '0;
         msk_q      <= '0;
         dat_q      <= '0;
         rd_pri     <= 1'b1;
         rd_vld_o   <= 1'b0;
         clr_done_o <= 1'b0;
      end else begin
         rd_vld_o   <= rd_ack_o;
         clr_done_o <= 1'b0;
         if (arb_ok && rd_req_i && wr_req_i)
            rd_pri <= !rd_ack_o;
         case (state)
            IDLE: begin
               if (clr_start_i) begin
                  state <= CLR;
                  cnt   <= '0;
               end else if (wr_ack_o) begin
                  adr_q <= wr_adr_i;
                  msk_q <= wr_msk_i;
                  dat_q <= wr_dat_i;
                  state <= RMW_WR;
               end
            end
            // a clear requested during the merge write starts right after it
            RMW_WR: begin
               if (clr_start_i) begin
                  state <= CLR;
                  cnt   <= '0;
               end else begin
                  state <= IDLE;
               end
            end
            CLR: begin
               cnt <= cnt + 6'd1;
               if (cnt == 6'd63) begin
                  state      <= IDLE;
                  clr_done_o <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
